mem_if_checker: RTL and testbench

Parametrised, synthesisable protocol checker for the core's request/grant memory ports. It observes NCH memory channels, for example imem and dmem, and checks each one against the handshake rules. Failures are recorded as sticky per-channel flags with a first-failure code, and completed transactions are counted. It sits beside the core in the verification top and in formal harnesses, is purely observational, and never drives the memory interfaces.

---
 rtl/mem_if_checker.sv | 165 ++++++++++++++++
 tb/tb_mem_if_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_if_checker.sv
// mem_if_checker: passive request/grant protocol checker for NCH memory channels.
//   clock, g_resetn    : clock (rising edge), asynchronous active-low reset
//   chk_clear          : synchronous clear of the sticky failure state
//   mem_req/addr/wen/strb/wdata/gnt/err : observed channel signals, channel c in slice c
//   chk_fail, chk_code : sticky failure flag and first-failure code per channel
//   chk_any            : OR of chk_fail
//   txn_count          : saturating count of req&&gnt cycles per channel
// Every output comes straight from a flop (chk_fail/chk_any only OR flop bits).

module mem_if_chk_lane #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int STRB_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clock,
  input  logic              g_resetn,
  input  logic              chk_clear,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wen,
  input  logic [STRB_W-1:0] strb,
  input  logic [DATA_W-1:0] wdata,
  input  logic              gnt,
  input  logic              err,
  output logic [2:0]        code,
  output logic [CNT_W-1:0]  txn
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_FIRE = WAIT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] wdata;
  } pay_t;

  typedef enum logic [2:0] {
    C_NONE       = 3'd0,
    C_REQ_DROP   = 3'd1,
    C_PAY_CHANGE = 3'd2,
    C_TIMEOUT    = 3'd3,
    C_STRB_ZERO  = 3'd4,
    C_ERR_NO_GNT = 3'd5,
    C_GNT_NO_REQ = 3'd6
  } code_e;

  logic              pend_q, pend_d;
  pay_t              snap_q, snap_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  code_e             code_q, code_d;
  logic [CNT_W-1:0]  txn_q,  txn_d;

  pay_t  cur;
  logic  stall, pay_diff;
  code_e viol;

  always_comb begin
    cur   = '{addr: addr, wen: wen, strb: strb, wdata: wdata};
    stall = req && !gnt;
    // strb/wdata only matter for a write that was captured as a write
    pay_diff = (addr != snap_q.addr) || (wen != snap_q.wen) ||
               (snap_q.wen && ((strb != snap_q.strb) || (wdata != snap_q.wdata)));

    viol = C_NONE;
    if (pend_q && !req)                                 viol = C_REQ_DROP;
    else if (pend_q && req && pay_diff)                 viol = C_PAY_CHANGE;
    else if ((TIMEOUT != 0) && stall && (wait_q == WAIT_FIRE)) viol = C_TIMEOUT;
    else if (req && wen && (strb == '0))                viol = C_STRB_ZERO;
    else if (err && !gnt)                               viol = C_ERR_NO_GNT;
    else if (gnt && !req)                               viol = C_GNT_NO_REQ;

    // first failure sticks; a clear still lets a same-cycle violation load
    code_d = code_q;
    if (chk_clear || (code_q == C_NONE)) code_d = viol;

    wait_d = '0;
    if (stall) wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;

    txn_d = txn_q;
    if (req && gnt && (txn_q != '1)) txn_d = txn_q + 1'b1;

    pend_d = stall;
    snap_d = snap_q;
    if (stall && !pend_q) snap_d = cur;
  end

  always_ff @(posedge clock or negedge g_resetn) begin
    if (!g_resetn) begin
      pend_q <= 1'b0;
      snap_q <= '0;
      wait_q <= '0;
      code_q <= C_NONE;
      txn_q  <= '0;
    end else begin
      pend_q <= pend_d;
      snap_q <= snap_d;
      wait_q <= wait_d;
      code_q <= code_d;
      txn_q  <= txn_d;
    end
  end

  assign code = code_q;
  assign txn  = txn_q;

endmodule

module mem_if_checker #(
  parameter int NCH     = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                  clock,
  input  logic                  g_resetn,
  input  logic                  chk_clear,
  input  logic [NCH-1:0]        mem_req,
  input  logic [NCH*ADDR_W-1:0] mem_addr,
  input  logic [NCH-1:0]        mem_wen,
  input  logic [NCH*STRB_W-1:0] mem_strb,
  input  logic [NCH*DATA_W-1:0] mem_wdata,
  input  logic [NCH-1:0]        mem_gnt,
  input  logic [NCH-1:0]        mem_err,
  output logic [NCH-1:0]        chk_fail,
  output logic [NCH*3-1:0]      chk_code,
  output logic                  chk_any,
  output logic [NCH*CNT_W-1:0]  txn_count
);

  logic [NCH-1:0][2:0]       code;
  logic [NCH-1:0][CNT_W-1:0] txn;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    mem_if_chk_lane #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W),
      .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_lane (
      .clock    (clock),
      .g_resetn (g_resetn),
      .chk_clear(chk_clear),
      .req      (mem_req[c]),
      .addr     (mem_addr[c*ADDR_W +: ADDR_W]),
      .wen      (mem_wen[c]),
      .strb     (mem_strb[c*STRB_W +: STRB_W]),
      .wdata    (mem_wdata[c*DATA_W +: DATA_W]),
      .gnt      (mem_gnt[c]),
      .err      (mem_err[c]),
      .code     (code[c]),
      .txn      (txn[c])
    );
    assign chk_fail[c] = |code[c];
  end

  assign chk_code  = code;
  assign txn_count = txn;
  assign chk_any   = |chk_fail;

endmodule

// File: tb/tb_mem_if_checker.sv
// Bench for mem_if_checker: two instances share one stimulus bus, a default one
// (TIMEOUT=16, CNT_W=32) and a small one (TIMEOUT=4, CNT_W=4). Directed
// scenarios use constants; random traffic is checked against a rule-level model.
module tb_mem_if_checker;

  localparam int NCH = 2;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int SW  = 8;

  logic clock = 1'b0;
  logic g_resetn = 1'b0;
  logic chk_clear = 1'b0;
  logic [NCH-1:0]    mem_req = '0, mem_wen = '0, mem_gnt = '0, mem_err = '0;
  logic [NCH*AW-1:0] mem_addr = '0;
  logic [NCH*SW-1:0] mem_strb = '0;
  logic [NCH*DW-1:0] mem_wdata = '0;

  logic [NCH-1:0]    fail_a, fail_b;
  logic [NCH*3-1:0]  code_a, code_b;
  logic              any_a, any_b;
  logic [NCH*32-1:0] cnt_a;
  logic [NCH*4-1:0]  cnt_b;

  always #5 clock = ~clock;

  mem_if_checker #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16), .CNT_W(32)) dut_a (
    .clock(clock), .g_resetn(g_resetn), .chk_clear(chk_clear),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_err(mem_err),
    .chk_fail(fail_a), .chk_code(code_a), .chk_any(any_a), .txn_count(cnt_a));

  mem_if_checker #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4), .CNT_W(4)) dut_b (
    .clock(clock), .g_resetn(g_resetn), .chk_clear(chk_clear),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_err(mem_err),
    .chk_fail(fail_b), .chk_code(code_b), .chk_any(any_b), .txn_count(cnt_b));

  int checks = 0;
  int errors = 0;
  int exp_txn [NCH];

  // Reference model: k=0 is dut_a, k=1 is dut_b.
  int     to_lim [2] = '{16, 4};
  longint cnt_max[2] = '{64'hFFFF_FFFF, 15};
  bit          m_pend [NCH];
  int          m_stall[NCH];
  logic [63:0] m_saddr[NCH], m_sdata[NCH];
  logic        m_swen [NCH];
  logic [7:0]  m_sstrb[NCH];
  int          m_code [2][NCH];
  longint      m_txn  [2][NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pend[c] = 0; m_stall[c] = 0;
      for (int k = 0; k < 2; k++) begin m_code[k][c] = 0; m_txn[k][c] = 0; end
    end
  endtask

  task automatic model_step();
    logic r, g, e, w, chg;
    logic [63:0] a, d;
    logic [7:0] s;
    int v;
    for (int c = 0; c < NCH; c++) begin
      r = mem_req[c]; g = mem_gnt[c]; e = mem_err[c]; w = mem_wen[c];
      a = mem_addr[c*AW +: AW]; d = mem_wdata[c*DW +: DW]; s = mem_strb[c*SW +: SW];
      chg = m_pend[c] && r && (a != m_saddr[c] || w != m_swen[c] ||
            (m_swen[c] && (s != m_sstrb[c] || d != m_sdata[c])));
      for (int k = 0; k < 2; k++) begin
        v = 0;
        if (g && !r) v = 6;
        if (e && !g) v = 5;
        if (r && w && s == 0) v = 4;
        if (to_lim[k] != 0 && r && !g && m_stall[c] == to_lim[k] - 1) v = 3;
        if (chg) v = 2;
        if (m_pend[c] && !r) v = 1;
        if (chk_clear || m_code[k][c] == 0) m_code[k][c] = v;
        if (r && g && m_txn[k][c] < cnt_max[k]) m_txn[k][c]++;
      end
      if (r && !g) begin
        if (!m_pend[c]) begin
          m_saddr[c] = a; m_swen[c] = w; m_sstrb[c] = s; m_sdata[c] = d;
        end
        m_pend[c] = 1; m_stall[c]++;
      end else begin
        m_pend[c] = 0; m_stall[c] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    if (g_resetn) model_step();
    #1;
  endtask

  task automatic idle();
    mem_req = '0; mem_wen = '0; mem_gnt = '0; mem_err = '0;
    mem_addr = '0; mem_strb = '0; mem_wdata = '0; chk_clear = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic r, input logic [63:0] a, input logic w,
                        input logic [7:0] s, input logic [63:0] d, input logic g, input logic e);
    mem_req[c] = r; mem_addr[c*AW +: AW] = a; mem_wen[c] = w;
    mem_strb[c*SW +: SW] = s; mem_wdata[c*DW +: DW] = d; mem_gnt[c] = g; mem_err[c] = e;
  endtask

  task automatic clear();
    idle(); chk_clear = 1'b1; cycle(); chk_clear = 1'b0;
  endtask

  task automatic test_reset();
    idle(); g_resetn = 1'b0; model_reset();
    cycle(); cycle();
    checks++; if (fail_a !== '0 || fail_b !== '0) begin errors++; $display("FAIL reset_fail: got %b/%b want 0", fail_a, fail_b); end
    checks++; if (code_a !== '0 || code_b !== '0) begin errors++; $display("FAIL reset_code: got %h/%h want 0", code_a, code_b); end
    checks++; if (any_a !== 1'b0 || any_b !== 1'b0) begin errors++; $display("FAIL reset_any: got %b/%b want 0", any_a, any_b); end
    checks++; if (cnt_a !== '0 || cnt_b !== '0) begin errors++; $display("FAIL reset_cnt: got %h/%h want 0", cnt_a, cnt_b); end
    g_resetn = 1'b1;
    for (int c = 0; c < NCH; c++) exp_txn[c] = 0;
  endtask

  task automatic test_legal();
    int c, dly;
    logic [63:0] a, d;
    logic w;
    logic [7:0] s;
    for (int n = 0; n < 100; n++) begin
      c = $urandom_range(0, 1);
      a = {$urandom, $urandom}; d = {$urandom, $urandom};
      w = 1'($urandom_range(0, 1)); s = 8'($urandom_range(1, 255));
      dly = $urandom_range(0, 10);
      set_ch(1 - c, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < dly; i++) begin set_ch(c, 1, a, w, s, d, 0, 0); cycle(); end
      set_ch(c, 1, a, w, s, d, 1, 0); cycle(); exp_txn[c]++;
      if ($urandom_range(0, 1) == 1) begin idle(); cycle(); end
    end
    idle(); cycle();
    checks++; if (any_a !== 1'b0) begin errors++; $display("FAIL legal_any: got %b code %h want 0", any_a, code_a); end
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (cnt_a[k*32 +: 32] !== 32'(exp_txn[k])) begin
        errors++; $display("FAIL legal_cnt ch%0d: got %0d want %0d", k, cnt_a[k*32 +: 32], exp_txn[k]);
      end
      checks++;
      if (cnt_b[k*4 +: 4] !== 4'((exp_txn[k] > 15) ? 15 : exp_txn[k])) begin
        errors++; $display("FAIL legal_cnt_sat ch%0d: got %0d want %0d", k, cnt_b[k*4 +: 4], exp_txn[k]);
      end
    end
  endtask

  task automatic test_payload_change();
    clear();
    set_ch(0, 1, 64'h1000, 0, 0, 0, 0, 0); cycle();
    checks++; if (code_a[2:0] !== 3'd0) begin errors++; $display("FAIL pay_first_stall: got %0d want 0", code_a[2:0]); end
    set_ch(0, 1, 64'h1008, 0, 0, 0, 0, 0); cycle();
    checks++; if (code_a[2:0] !== 3'd2 || code_b[2:0] !== 3'd2) begin errors++; $display("FAIL pay_code: got %0d/%0d want 2", code_a[2:0], code_b[2:0]); end
    checks++; if (code_a[5:3] !== 3'd0) begin errors++; $display("FAIL pay_ch1: got %0d want 0", code_a[5:3]); end
    checks++; if (fail_a !== 2'b01 || any_a !== 1'b1) begin errors++; $display("FAIL pay_flags: got %b/%b want 01/1", fail_a, any_a); end
    idle(); cycle();
    checks++; if (code_a[2:0] !== 3'd2) begin errors++; $display("FAIL pay_sticky: got %0d want 2", code_a[2:0]); end
  endtask

  task automatic test_timeout();
    clear();
    for (int k = 1; k <= 6; k++) begin
      set_ch(1, 1, 64'h2000, 1, 8'hFF, 64'hDEAD, 0, 0); cycle();
      checks++;
      if (fail_b[1] !== (k >= 4) || code_b[5:3] !== ((k >= 4) ? 3'd3 : 3'd0)) begin
        errors++; $display("FAIL timeout_k%0d: got fail %b code %0d want fail %0d", k, fail_b[1], code_b[5:3], k >= 4);
      end
    end
    checks++; if (fail_a[1] !== 1'b0) begin errors++; $display("FAIL timeout_long_limit: got %b want 0", fail_a[1]); end
    idle(); cycle();
    checks++; if (code_b[5:3] !== 3'd3) begin errors++; $display("FAIL timeout_sticky: got %0d want 3", code_b[5:3]); end
    checks++; if (code_a[5:3] !== 3'd1) begin errors++; $display("FAIL timeout_drop_a: got %0d want 1", code_a[5:3]); end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < NCH; c++) set_ch(c, 1, 64'h3000, 1, 8'h00, 64'h0, 0, 1);
    chk_clear = 1'b1; cycle(); chk_clear = 1'b0;
    checks++; if (code_a !== {3'd4, 3'd4}) begin errors++; $display("FAIL simul_a: got %h want 24", code_a); end
    checks++; if (code_b !== {3'd4, 3'd4}) begin errors++; $display("FAIL simul_b: got %h want 24", code_b); end
    idle(); cycle();
    checks++; if (code_a !== {3'd4, 3'd4}) begin errors++; $display("FAIL simul_sticky: got %h want 24", code_a); end
  endtask

  task automatic test_clear();
    idle(); chk_clear = 1'b1; cycle(); chk_clear = 1'b0;
    checks++; if (fail_a !== '0 || fail_b !== '0) begin errors++; $display("FAIL clear_fail: got %b/%b want 0", fail_a, fail_b); end
    checks++; if (any_a !== 1'b0 || any_b !== 1'b0) begin errors++; $display("FAIL clear_any: got %b/%b want 0", any_a, any_b); end
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (cnt_a[k*32 +: 32] !== 32'(exp_txn[k])) begin
        errors++; $display("FAIL clear_cnt ch%0d: got %0d want %0d", k, cnt_a[k*32 +: 32], exp_txn[k]);
      end
    end
  endtask

  task automatic test_saturation();
    idle(); g_resetn = 1'b0; model_reset(); cycle(); g_resetn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      set_ch(0, 1, 64'h40, 0, 0, 0, 1, 0); cycle();
      checks++;
      if (cnt_b[3:0] !== 4'((i > 15) ? 15 : i)) begin errors++; $display("FAIL sat_b i%0d: got %0d want %0d", i, cnt_b[3:0], (i > 15) ? 15 : i); end
      checks++;
      if (cnt_a[31:0] !== 32'(i)) begin errors++; $display("FAIL sat_a i%0d: got %0d want %0d", i, cnt_a[31:0], i); end
    end
    idle(); cycle();
    checks++; if (any_a !== 1'b0) begin errors++; $display("FAIL sat_clean: got code %h want 0", code_a); end
  endtask

  task automatic test_reset_mid_stall();
    set_ch(0, 1, 64'h5000, 1, 8'h0F, 64'h1234, 0, 0); cycle(); cycle();
    #2; g_resetn = 1'b0; model_reset(); #1;
    checks++; if (cnt_a !== '0 || cnt_b !== '0) begin errors++; $display("FAIL midrst_cnt: got %h/%h want 0", cnt_a, cnt_b); end
    checks++; if (code_a !== '0 || code_b !== '0 || any_a !== 1'b0) begin errors++; $display("FAIL midrst_code: got %h/%h want 0", code_a, code_b); end
    idle(); cycle(); g_resetn = 1'b1;
    set_ch(0, 0, 0, 0, 0, 0, 1, 0); cycle();
    checks++; if (code_a !== {3'd0, 3'd6}) begin errors++; $display("FAIL midrst_gnt_a: got %h want 06", code_a); end
    checks++; if (code_b !== {3'd0, 3'd6}) begin errors++; $display("FAIL midrst_gnt_b: got %h want 06", code_b); end
    idle(); cycle();
  endtask

  task automatic test_random();
    logic [63:0] ra[NCH], rd[NCH];
    logic rw[NCH];
    logic [7:0] rs[NCH];
    logic [5:0] ea, eb;
    for (int c = 0; c < NCH; c++) begin ra[c] = 64'h100; rd[c] = 64'h0; rw[c] = 0; rs[c] = 8'h1; end
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) ra[c] = 64'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) rd[c] = 64'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) rw[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) rs[c] = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom_range(1, 3));
        set_ch(c, $urandom_range(0, 3) != 0, ra[c], rw[c], rs[c], rd[c],
               $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      end
      chk_clear = ($urandom_range(0, 7) == 0);
      cycle();
      for (int c = 0; c < NCH; c++) begin
        ea[c*3 +: 3] = 3'(m_code[0][c]);
        eb[c*3 +: 3] = 3'(m_code[1][c]);
        checks++;
        if (cnt_a[c*32 +: 32] !== 32'(m_txn[0][c])) begin errors++; $display("FAIL rnd_cnt_a n%0d ch%0d: got %0d want %0d", n, c, cnt_a[c*32 +: 32], m_txn[0][c]); end
        checks++;
        if (cnt_b[c*4 +: 4] !== 4'(m_txn[1][c])) begin errors++; $display("FAIL rnd_cnt_b n%0d ch%0d: got %0d want %0d", n, c, cnt_b[c*4 +: 4], m_txn[1][c]); end
      end
      checks++; if (code_a !== ea) begin errors++; $display("FAIL rnd_code_a n%0d: got %h want %h", n, code_a, ea); end
      checks++; if (code_b !== eb) begin errors++; $display("FAIL rnd_code_b n%0d: got %h want %h", n, code_b, eb); end
      checks++; if (any_a !== (ea != 0) || any_b !== (eb != 0)) begin errors++; $display("FAIL rnd_any n%0d: got %b/%b want %b/%b", n, any_a, any_b, ea != 0, eb != 0); end
    end
    idle(); cycle();
  endtask

  initial begin
    test_reset();
    test_legal();
    test_payload_change();
    test_timeout();
    test_simultaneous();
    test_clear();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
